// File: rtl/fadd_wb_ctrl.sv
// Issue/writeback controller for a fixed-latency fadd: tags ride a valid delay line
// alongside the adder, results land in a credit-protected FIFO for the consumer.
module fadd_wb_ctrl #(
  parameter int NSTAGE = 2,
  parameter int DEPTH  = 4,
  parameter int TAGW   = 5
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_x1,
  input  logic [31:0]            in_x2,
  input  logic [TAGW-1:0]        in_tag,
  output logic [31:0]            fa_x1,
  output logic [31:0]            fa_x2,
  input  logic [31:0]            fa_y,
  input  logic                   fa_ovf,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_y,
  output logic                   out_ovf,
  output logic [TAGW-1:0]        out_tag,
  output logic [$clog2(DEPTH):0] credits
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0]     y;
    logic            ovf;
    logic [TAGW-1:0] tag;
  } ent_t;

  logic [NSTAGE-1:0]           vld_q, vld_d;
  logic [NSTAGE-1:0][TAGW-1:0] tag_q, tag_d;
  logic [AW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]                 cnt_q, cnt_d, cred_q, cred_d;
  ent_t                        mem_q [DEPTH];
  logic                        acc, pop, wr;

  assign fa_x1     = in_x1;
  assign fa_x2     = in_x2;
  assign in_ready  = cred_q < (AW+1)'(DEPTH);
  assign out_valid = cnt_q != '0;
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign wr        = vld_q[NSTAGE-1];
  assign out_y     = mem_q[rptr_q].y;
  assign out_ovf   = mem_q[rptr_q].ovf;
  assign out_tag   = mem_q[rptr_q].tag;
  assign credits   = cred_q;

  always_comb begin
    vld_d    = '0;
    tag_d    = tag_q;
    vld_d[0] = acc;
    tag_d[0] = in_tag;
    for (int i = 1; i < NSTAGE; i++) begin
      vld_d[i] = vld_q[i-1];
      tag_d[i] = tag_q[i-1];
    end
    wptr_d = wptr_q + AW'(wr);
    rptr_d = rptr_q + AW'(pop);
    cnt_d  = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    // A credit is held from accept until pop; the FIFO write itself is credit-neutral.
    cred_d = cred_q + (AW+1)'(acc) - (AW+1)'(pop);
    if (flush) begin
      vld_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
      cred_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vld_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      cred_q <= '0;
    end else begin
      vld_q  <= vld_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      cred_q <= cred_d;
    end
  end

  // Payload storage is never reset; validity lives only in the pointers and counts.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    if (wr) mem_q[wptr_q] <= '{y: fa_y, ovf: fa_ovf, tag: tag_q[NSTAGE-1]};
  end

endmodule
